// File: rtl/mc_pi_sampler.sv
`default_nettype none
// ============================================================================
// Module   : mc_pi_sampler
// Purpose  : Monte Carlo pi estimator. Each RUN cycle it takes (rnd1, rnd2)
//            as a point in the 256x256 square and counts the points that lie
//            strictly inside the quarter circle of radius 256. The host reads
//            hits/count after a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mc_pi_sampler #(
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rnd1,
    input  logic [7:0]    rnd2,
    input  logic          start,
    input  logic [NW-1:0] n_samples,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] hits,
    output logic [NW-1:0] count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // 2^16: the squared radius of the quarter circle
    localparam logic [16:0] c_R_SQ = 17'h1_0000;

    logic [1:0]    r_state;
    logic [NW-1:0] r_remaining;
    logic [NW-1:0] r_count;
    logic [NW-1:0] r_hits;
    logic          r_v1;
    logic [15:0]   r_sq_x;
    logic [15:0]   r_sq_y;
    logic          r_busy;
    logic          r_done;

    logic [15:0]   w_sq_x;
    logic [15:0]   w_sq_y;
    logic [16:0]   w_sum;
    logic          w_hit;

    // Stage-1 squares of the incoming point and stage-2 hit decision.
    // The sum is kept at 17 bits so 255^2+255^2 cannot wrap into a false hit.
    always_comb begin
        w_sq_x = 16'(rnd1) * 16'(rnd1);
        w_sq_y = 16'(rnd2) * 16'(rnd2);
        w_sum  = {1'b0, r_sq_x} + {1'b0, r_sq_y};
        w_hit  = (w_sum < c_R_SQ);
    end

    // Control FSM, two-stage sample pipeline and result counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_remaining <= '0;
            r_count     <= '0;
            r_hits      <= '0;
            r_v1        <= 1'b0;
            r_sq_x      <= '0;
            r_sq_y      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Stage-1 valid only survives an edge taken in RUN; done is a pulse.
            r_v1   <= 1'b0;
            r_done <= 1'b0;

            // Stage 2 retires the sample captured on the previous edge.
            if (r_v1) begin
                r_hits <= r_hits + NW'(w_hit);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_hits      <= '0;
                        r_count     <= '0;
                        r_remaining <= n_samples;
                        if (n_samples != '0) begin
                            r_state <= c_ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_sq_x      <= w_sq_x;
                    r_sq_y      <= w_sq_y;
                    r_v1        <= 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_count     <= r_count + 1'b1;
                    if (r_remaining == NW'(1)) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    // Last sample retires on this edge; nothing new is captured.
                    r_state <= c_ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign hits  = r_hits;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mc_pi_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_pi_sampler
// Purpose  : Self-checking bench for mc_pi_sampler. Stimulus pushes the
//            expected result of each run into a scoreboard queue; a monitor
//            pops and compares whenever done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_pi_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rnd1;
    logic [7:0]  rnd2;
    logic        start;
    logic [15:0] n_samples;
    logic        busy;
    logic        done;
    logic [15:0] hits;
    logic [15:0] count;

    mc_pi_sampler #(.NW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rnd1      (rnd1),
        .rnd2      (rnd2),
        .start     (start),
        .n_samples (n_samples),
        .busy      (busy),
        .done      (done),
        .hits      (hits),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hits;
        int count;
        int busy_cycles;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   n_done   = 0;
    int   busy_cnt = 0;
    int   last_hits = 0;
    int   px[$];
    int   py[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest pending expectation.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("hits", int'(hits), mon_e.hits);
                    chk("count", int'(count), mon_e.count);
                    chk("busy_cycles", busy_cnt, mon_e.busy_cycles);
                    chk("done_cycle", cyc, mon_e.done_cyc);
                end
                last_hits = int'(hits);
                n_done++;
                busy_cnt = 0;
            end
        end
    end

    // Reference rule: a point is a hit when x^2 + y^2 < 65536.
    function automatic int model_hits(input int n);
        int h = 0;
        for (int i = 0; i < n; i++) begin
            if (px[i] * px[i] + py[i] * py[i] < 65536) h++;
        end
        return h;
    endfunction

    function automatic int unsigned xorshift(input int unsigned s);
        int unsigned t = s;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic fill_seeded(input int n, input int unsigned seed);
        int unsigned s = seed;
        px.delete();
        py.delete();
        for (int i = 0; i < n; i++) begin
            s = xorshift(s);
            px.push_back(int'(s & 32'hFF));
            py.push_back(int'((s >> 8) & 32'hFF));
        end
    endtask

    task automatic fill_random(input int n);
        int x;
        int y;
        px.delete();
        py.delete();
        for (int i = 0; i < n; i++) begin
            x = int'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                // Point close to the circle edge
                y = int'($sqrt(65536.0 - real'(x * x))) + int'($urandom_range(0, 4)) - 2;
                if (y < 0) y = 0;
                if (y > 255) y = 255;
            end else begin
                y = int'($urandom_range(0, 255));
            end
            px.push_back(x);
            py.push_back(y);
        end
    endtask

    // Issue one run over px/py; called with the bench inside an IDLE cycle.
    task automatic run(input int n, input bit hold_start);
        exp_t e;
        int   c0;
        int   target;
        target    = n_done + 1;
        start     = 1'b1;
        n_samples = 16'(n);
        @(posedge clk); #1;
        c0 = cyc;
        if (!hold_start) start = 1'b0;
        e.hits        = model_hits(n);
        e.count       = n;
        e.busy_cycles = (n == 0) ? 0 : n + 1;
        e.done_cyc    = (n == 0) ? c0 : c0 + n + 1;
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            rnd1 = 8'(px[i]);
            rnd2 = 8'(py[i]);
            @(posedge clk); #1;
        end
        rnd1 = 8'($urandom);
        rnd2 = 8'($urandom);
        for (int k = 0; k < 20 && n_done < target; k++) begin
            @(negedge clk); #1;
        end
        start = 1'b0;
        if (n_done < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected one within %0d cycles", n + 20);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int h_mid;
        reset     = 1'b1;
        start     = 1'b0;
        rnd1      = 8'd0;
        rnd2      = 8'd0;
        n_samples = 16'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_hits", int'(hits), 0);
        chk("idle_count", int'(count), 0);

        // Single origin point
        px = '{0};
        py = '{0};
        run(1, 1'b0);

        // Boundary points: 65025, 65025, 65522 hit; 130050 misses
        px = '{255, 0, 181, 255};
        py = '{0, 255, 181, 255};
        run(4, 1'b0);

        // 65668 just outside
        px = '{128};
        py = '{222};
        run(1, 1'b0);

        // Empty run
        px.delete();
        py.delete();
        run(0, 1'b0);

        // start held high throughout a run must not restart it
        fill_random(10);
        run(10, 1'b1);
        repeat (5) @(posedge clk);
        #1;

        // Randomized runs, back to back
        for (int r = 0; r < 6; r++) begin
            fill_random(int'($urandom_range(1, 30)));
            run(px.size(), 1'b0);
        end

        // Reset in the middle of an N=100 run
        fill_random(100);
        start     = 1'b1;
        n_samples = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rnd1 = 8'(px[i]);
            rnd2 = 8'(py[i]);
            @(posedge clk); #1;
        end
        h_mid = model_hits(39);
        chk("mid_count", int'(count), 40);
        chk("mid_hits_lag", int'(hits), h_mid);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_hits", int'(hits), 0);
        chk("abort_count", int'(count), 0);
        repeat (110) @(posedge clk);
        #1;

        // Long seeded runs, repeated with the same seed
        for (int r = 0; r < 2; r++) begin
            fill_seeded(4096, 32'h1234_5678);
            run(4096, 1'b0);
            checks++;
            if (last_hits < 3117 || last_hits > 3317) begin
                errors++;
                $display("FAIL pi_range: got %0d expected 3117..3317", last_hits);
            end
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
